// File: rtl/stopwatch_control.sv
// Stopwatch control and time base.
// Conditions the start and clear pushbuttons, sequences IDLE/RUN/PAUSED and
// produces the hundredths tick and the clear pulse for the BCD counter chain.

// Per-key input conditioning: two-flop synchroniser, then a debounce counter
// that accepts a level change only after DB_CYCLES consecutive differing
// samples. A press is a one-cycle pulse on the accepted 1->0 transition.
module stopwatch_key_filter #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_meta;
  logic          sync_key;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop gets an explicit reset value; released (1) for the
    // synchroniser so a reset never looks like a press edge.
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_key  <= 1'b1;
    end else begin
      // NOTE: non-blocking so sync_key takes the pre-edge sync_meta, giving
      // two real flop stages instead of one collapsed wire.
      sync_meta <= key_n;
      sync_key  <= sync_meta;
    end
  end

  // Debounce: restart on any sample matching the accepted level, flip the
  // level after DB_CYCLES consecutive mismatches, flag a press on 1->0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_key == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_key;
        press <= ~sync_key;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

module stopwatch_control #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 500_000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic key_start_n,
  input  logic key_clear_n,
  output logic tick,
  output logic running,
  output logic clear
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          start_press;
  logic          clear_press;
  logic [PW-1:0] prescale;
  logic          wrap;

  stopwatch_key_filter #(.DB_CYCLES(DB_CYCLES)) u_start_key (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .key_n (key_start_n),
    .press (start_press)
  );

  stopwatch_key_filter #(.DB_CYCLES(DB_CYCLES)) u_clear_key (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .key_n (key_clear_n),
    .press (clear_press)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start toggles RUN/PAUSED (IDLE starts), clear always wins.
  always_comb begin
    // NOTE: hold the current state by default so every path assigns
    // state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:   if (start_press) state_next = ST_RUN;
      ST_RUN:    if (start_press) state_next = ST_PAUSED;
      ST_PAUSED: if (start_press) state_next = ST_RUN;
      default:   state_next = ST_IDLE;
    endcase
    if (clear_press) begin
      state_next = ST_IDLE;
    end
  end

  // Output decode: running follows the state register directly.
  always_comb begin
    running = (state == ST_RUN);
  end

  // A wrap only happens when RUN continues across the edge; leaving RUN at
  // the terminal count holds the prescaler at DIV-1 so resume ticks at once.
  assign wrap = (state == ST_RUN) && (state_next == ST_RUN) && (prescale == PS_LAST);

  // Prescaler with registered tick and clear pulses.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      tick     <= 1'b0;
      clear    <= 1'b0;
    end else begin
      tick  <= wrap;
      clear <= clear_press;
      if (clear_press) begin
        prescale <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (prescale == PS_LAST) begin
              if (state_next == ST_RUN) begin
                prescale <= '0;
              end
            end else begin
              prescale <= prescale + PW'(1);
            end
          end
          ST_PAUSED: prescale <= prescale;
          default:   prescale <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed vector table, reset sequences and
// randomized key activity against a behavioural reference model.
module tb_stopwatch_control;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DB      = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start_n = 1'b1;
  logic clr_n   = 1'b1;
  logic tick;
  logic running;
  logic clear;

  int n_checks    = 0;
  int n_pass      = 0;
  int seen_ticks  = 0;
  int seen_clears = 0;

  always #5 clk = ~clk;

  stopwatch_control #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .DB_CYCLES (DB)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (rst_n),
    .key_start_n (start_n),
    .key_clear_n (clr_n),
    .tick        (tick),
    .running     (running),
    .clear       (clear)
  );

  // ---------------- reference model ----------------
  // A key is seen two edges late; its accepted level changes once DB
  // consecutive seen samples differ from it. A press is acting on the edge
  // after the level is accepted low.
  typedef struct packed {
    logic [1:0] pipe;
    logic       lvl;
    int         run;
    logic       evt;
  } key_m_t;

  localparam key_m_t KEY_IDLE = '{pipe: 2'b11, lvl: 1'b1, run: 0, evt: 1'b0};

  key_m_t m_start;
  key_m_t m_clr;
  logic   m_active;
  logic   m_counting;
  logic   m_tick;
  logic   m_clear;
  int     m_phase;
  logic   m_running;

  assign m_running = m_active && m_counting;

  function automatic key_m_t key_step(input key_m_t k, input logic raw);
    key_m_t n;
    n      = k;
    n.pipe = {k.pipe[0], raw};
    n.evt  = 1'b0;
    if (k.pipe[1] == k.lvl) begin
      n.run = 0;
    end else if (k.run + 1 == DB) begin
      n.lvl = k.pipe[1];
      n.run = 0;
      n.evt = ~k.pipe[1];
    end else begin
      n.run = k.run + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start    <= KEY_IDLE;
      m_clr      <= KEY_IDLE;
      m_active   <= 1'b0;
      m_counting <= 1'b0;
      m_phase    <= 0;
      m_tick     <= 1'b0;
      m_clear    <= 1'b0;
    end else begin
      m_start <= key_step(m_start, start_n);
      m_clr   <= key_step(m_clr, clr_n);
      m_clear <= m_clr.evt;
      m_tick  <= 1'b0;
      if (m_clr.evt) begin
        m_active   <= 1'b0;
        m_counting <= 1'b0;
        m_phase    <= 0;
      end else begin
        if (m_start.evt) begin
          m_active   <= 1'b1;
          m_counting <= m_active ? !m_counting : 1'b1;
        end
        if (m_running) begin
          if (m_phase < DIV - 1) begin
            m_phase <= m_phase + 1;
          end else if (!m_start.evt) begin
            m_phase <= 0;
            m_tick  <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one cycle, compare all outputs with the model, count pulses.
  task automatic step();
    @(negedge clk);
    check("outputs{tick,running,clear}_vs_model",
          int'({tick, running, clear}), int'({m_tick, m_running, m_clear}));
    seen_ticks  += int'(tick);
    seen_clears += int'(clear);
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_running"}, int'(running), 0);
    check({tag, "_clear"}, int'(clear), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic start_n;
    logic clr_n;
    int   cycles;
    logic exp_running;
    int   exp_ticks;
    int   exp_clears;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 50,  1'b0, 0, 0};  // idle after reset
    vecs[1]  = '{1'b0, 1'b1, 20,  1'b1, 1, 0};  // clean start, RUN at edge 7, tick at 17
    vecs[2]  = '{1'b1, 1'b1, 20,  1'b1, 2, 0};  // release: no event, ticks every 10
    vecs[3]  = '{1'b1, 1'b0, 10,  1'b0, 0, 1};  // clear lands on the wrap edge
    vecs[4]  = '{1'b1, 1'b1, 10,  1'b0, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 3,   1'b0, 0, 0};  // bounce runs of 3
    vecs[6]  = '{1'b1, 1'b1, 3,   1'b0, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 3,   1'b0, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 3,   1'b0, 0, 0};
    vecs[9]  = '{1'b0, 1'b1, 12,  1'b1, 0, 0};  // stable press -> RUN
    vecs[10] = '{1'b1, 1'b1, 4,   1'b1, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 7,   1'b0, 1, 0};  // pause with prescaler at 6
    vecs[12] = '{1'b1, 1'b1, 100, 1'b0, 0, 0};  // paused: no ticks
    vecs[13] = '{1'b0, 1'b1, 7,   1'b1, 0, 0};  // resume
    vecs[14] = '{1'b0, 1'b1, 4,   1'b1, 1, 0};  // tick 4 cycles after resume
    vecs[15] = '{1'b0, 1'b1, 10,  1'b1, 1, 0};
    vecs[16] = '{1'b1, 1'b1, 10,  1'b1, 1, 0};
    vecs[17] = '{1'b0, 1'b1, 7,   1'b0, 0, 0};  // pause
    vecs[18] = '{1'b1, 1'b1, 10,  1'b0, 0, 0};
    vecs[19] = '{1'b0, 1'b0, 7,   1'b0, 0, 1};  // start+clear together: clear wins
    vecs[20] = '{1'b1, 1'b1, 10,  1'b0, 0, 0};
    vecs[21] = '{1'b0, 1'b1, 17,  1'b1, 1, 0};  // fresh start after clear: tick at +10
    vecs[22] = '{1'b1, 1'b1, 8,   1'b1, 0, 0};  // mid-period
  end

  // ---------------- main sequence ----------------
  initial begin
    int len;

    rst_n   = 1'b0;
    start_n = 1'b1;
    clr_n   = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_low("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      start_n     = vecs[i].start_n;
      clr_n       = vecs[i].clr_n;
      seen_ticks  = 0;
      seen_clears = 0;
      repeat (vecs[i].cycles) step();
      check($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_running));
      check($sformatf("vec%0d_ticks", i), seen_ticks, vecs[i].exp_ticks);
      check($sformatf("vec%0d_clears", i), seen_clears, vecs[i].exp_clears);
    end

    // Reset in RUN mid-period clears outputs at once; no ticks afterwards.
    #2 rst_n = 1'b0;
    #1 check_outputs_low("async_reset_in_run");
    repeat (2) step();
    rst_n      = 1'b1;
    seen_ticks = 0;
    repeat (30) step();
    check("post_reset_ticks", seen_ticks, 0);
    check("post_reset_running", int'(running), 0);
    start_n = 1'b0;
    repeat (7) step();
    check("restart_running", int'(running), 1);

    // Key held down through reset release counts as a press after 2+DB edges.
    #2 rst_n = 1'b0;
    #1 check_outputs_low("async_reset_key_held");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    check("held_key_before_latency", int'(running), 0);
    step();
    check("held_key_press_after_reset", int'(running), 1);

    // Randomized key activity with occasional resets, checked every cycle.
    for (int seg = 0; seg < 400; seg++) begin
      start_n = 1'($urandom_range(0, 1));
      clr_n   = ($urandom_range(0, 11) == 0) ? 1'b0 : 1'b1;
      len     = $urandom_range(1, 12);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      repeat (len) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
